// File: rtl/data_bus.sv
// data_bus: data-side memory subsystem for a single-cycle core.
// Word-organised data RAM with byte/half/word store lanes, plus a
// memory-mapped 8N1 UART transmitter fed by a small TX FIFO.
// Loads are combinational; every state change happens on the rising edge.
module data_bus #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        we,
  input  logic [1:0]  mem_ctrl,
  output logic [31:0] read_data,
  output logic        uart_tx
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]      TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0]      STATUS_ADDR = 32'h1000_0004;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Storage
  logic [31:0] ram_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Control state
  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               uart_tx_q, uart_tx_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;

  // Decode and derived flags
  logic              ram_sel_c, tx_sel_c, st_sel_c, store_c;
  logic              ram_wr_c, tx_wr_c, st_wr_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [3:0]        be_c;
  logic [31:0]       wlanes_c;
  logic              empty_c, full_c, busy_c;
  logic              push_c, pop_c;

  // Address decode; mem_ctrl=11 suppresses every kind of store
  always_comb begin
    ram_sel_c = (addr[31:28] == 4'h0);
    tx_sel_c  = (addr == TXDATA_ADDR);
    st_sel_c  = (addr == STATUS_ADDR);
    store_c   = we && (mem_ctrl != 2'b11);
    ram_wr_c  = store_c && ram_sel_c;
    tx_wr_c   = store_c && tx_sel_c;
    st_wr_c   = store_c && st_sel_c;
    ram_idx_c = addr[RAM_AW+1:2];
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    be_c     = 4'b0000;
    wlanes_c = write_data;
    case (mem_ctrl)
      2'b00: begin
        be_c     = 4'b0001 << addr[1:0];
        wlanes_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_c     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes_c = {2{write_data[15:0]}};
      end
      2'b10: begin
        be_c     = 4'b1111;
        wlanes_c = write_data;
      end
      default: begin
        be_c     = 4'b0000;
        wlanes_c = write_data;
      end
    endcase
  end

  // Data RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (ram_wr_c) begin
      for (int l = 0; l < 4; l++) begin
        if (be_c[l]) ram_q[ram_idx_c][8*l +: 8] <= wlanes_c[8*l +: 8];
      end
    end
  end

  // FIFO flags: pointers carry an extra wrap bit to tell full from empty
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
              (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    busy_c  = (state_q != ST_IDLE);
  end

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= write_data[7:0];
  end

  // FIFO pointer and sticky overflow update; full is judged before the edge
  always_comb begin
    push_c   = tx_wr_c && !full_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(1);
    if (st_wr_c && write_data[3]) ovf_d = 1'b0;
    if (tx_wr_c && full_c)        ovf_d = 1'b1;
  end

  // Transmitter next-state: frame sequencing, bit timing and FIFO pops
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          shift_d   = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
          clk_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (!empty_c) begin
            // back-to-back frame: no idle gap after the stop bit
            pop_c   = 1'b1;
            shift_d = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so it is registered cleanly
    case (state_d)
      ST_START: uart_tx_d = 1'b0;
      ST_DATA:  uart_tx_d = shift_d[0];
      default:  uart_tx_d = 1'b1;
    endcase
  end

  // Control state registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Combinational load path keeps the core's single-cycle loads
  always_comb begin
    read_data = 32'h0;
    if (ram_sel_c) begin
      read_data = ram_q[ram_idx_c];
    end else if (st_sel_c) begin
      read_data = {28'h0, ovf_q, full_c, empty_c, busy_c};
    end
  end

  assign uart_tx = uart_tx_q;

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed stimulus for data_bus with a transaction-level
// reference model (byte-addressed RAM map, byte queue for the FIFO and a
// queue of expected line levels for the serial output).
module tb_data_bus;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam int unsigned RAM_AW     = 10;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CPB        = 4;
  localparam logic [31:0] TXA        = 32'h1000_0000;
  localparam logic [31:0] STA        = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        we = 1'b0;
  logic [1:0]  mem_ctrl = 2'b10;
  logic [31:0] read_data;
  logic        uart_tx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_bus #(
    .RAM_WORDS   (RAM_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .write_data(write_data),
    .we        (we),
    .mem_ctrl  (mem_ctrl),
    .read_data (read_data),
    .uart_tx   (uart_tx)
  );

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] fifo_m [$];
  bit         line_q [$];
  bit         ovf_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_line();
    return (line_q.size() > 0) ? line_q[0] : 1'b1;
  endfunction

  // Expected load value; returns 0 when the RAM word was never fully written
  function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a[31:28] == 4'h0) begin
      int base;
      base = int'(a[RAM_AW+1:2]) * 4;
      for (int l = 0; l < 4; l++) begin
        if (!ram_m.exists(base + l)) return 1'b0;
        v[8*l +: 8] = ram_m[base + l];
      end
      return 1'b1;
    end
    if (a == STA) begin
      v = {28'h0, ovf_m, fifo_m.size() == FIFO_DEPTH, fifo_m.size() == 0, line_q.size() > 0};
    end
    return 1'b1;
  endfunction

  // Model update on each edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_m.delete();
      line_q.delete();
      ovf_m = 1'b0;
    end else begin
      bit         wr;
      bit         full_pre;
      int         base;
      logic [7:0] b;
      wr       = we && (mem_ctrl != 2'b11);
      full_pre = (fifo_m.size() == FIFO_DEPTH);
      if (wr && addr[31:28] == 4'h0) begin
        base = int'(addr[RAM_AW+1:2]) * 4;
        case (mem_ctrl)
          2'b00: ram_m[base + int'(addr[1:0])] = write_data[7:0];
          2'b01: begin
            ram_m[base + (addr[1] ? 2 : 0)]     = write_data[7:0];
            ram_m[base + (addr[1] ? 2 : 0) + 1] = write_data[15:8];
          end
          default: for (int l = 0; l < 4; l++) ram_m[base + l] = write_data[8*l +: 8];
        endcase
      end
      // one line cycle elapses; when the line frees up a queued byte starts
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && fifo_m.size() > 0) begin
        b = fifo_m.pop_front();
        for (int i = 0; i < int'(CPB); i++) line_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
          for (int i = 0; i < int'(CPB); i++) line_q.push_back(b[k]);
        for (int i = 0; i < int'(CPB); i++) line_q.push_back(1'b1);
      end
      if (wr && addr == STA && write_data[3]) ovf_m = 1'b0;
      if (wr && addr == TXA) begin
        if (full_pre) ovf_m = 1'b1;
        else fifo_m.push_back(write_data[7:0]);
      end
    end
  end

  // Every-cycle comparison against the model
  logic [31:0] cmp_ev;
  always @(negedge clk) begin
    chk("uart_tx_model", {31'h0, uart_tx}, {31'h0, exp_line()});
    if (exp_read(addr, cmp_ev)) chk("read_data_model", read_data, cmp_ev);
  end

  // Called at posedge+1; one store cycle, returns at next posedge+1
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
    addr = a; write_data = d; mem_ctrl = c; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Called at posedge+1; reads at the negedge, returns at next posedge+1
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    @(negedge clk);
    chk(name, read_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fb;
    int         n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_uart", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;
    rd(STA, 32'h2, "reset_status");

    // RAM lanes, suppression, aliasing and unmapped space
    store(32'h40, 32'hDEAD_BEEF, 2'b10);
    store(32'h41, 32'h0000_0011, 2'b00);
    store(32'h42, 32'h0000_2233, 2'b01);
    rd(32'h40, 32'h2233_11EF, "ram_mixed_lanes");
    store(32'h40, 32'hFFFF_FFFF, 2'b11);
    rd(32'h40, 32'h2233_11EF, "ram_ctrl11_suppressed");
    rd(32'h2000_0000, 32'h0, "unmapped_read");
    rd(32'h40 + RAM_WORDS * 4, 32'h2233_11EF, "ram_alias");
    store(32'h2000_0040, 32'hFFFF_FFFF, 2'b10);
    rd(32'h40, 32'h2233_11EF, "unmapped_write_ignored");
    store(32'h80, 32'h0, 2'b10);
    store(32'h83, 32'h0000_005A, 2'b00);
    store(32'h81, 32'h0000_BEEF, 2'b01);
    rd(32'h80, 32'h5A00_BEEF, "ram_byte3_half_lo");
    rd(TXA, 32'h0, "txdata_read_zero");

    // Single frame 0xA5: start latency, bit order, busy length
    addr = TXA; write_data = 32'hA5; mem_ctrl = 2'b00; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; addr = STA;
    @(negedge clk);
    chk("tx_idle_after_push", {31'h0, uart_tx}, 32'h1);
    chk("status_after_push", read_data, 32'h0);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        @(posedge clk); @(negedge clk);
        chk($sformatf("a5_bit%0d", k), {31'h0, uart_tx}, {31'h0, fb[k]});
        chk("a5_busy", {31'h0, read_data[0]}, 32'h1);
      end
    end
    @(posedge clk); @(negedge clk);
    chk("a5_busy_end", read_data, 32'h2);
    chk("a5_line_idle", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;

    // Six consecutive pushes: one popped, four stored, sixth overflows
    for (int i = 0; i < 6; i++) begin
      addr = TXA; write_data = 32'h30 + 32'(i); mem_ctrl = 2'b10; we = 1'b1;
      @(posedge clk); #1;
    end
    we = 1'b0; addr = STA;
    @(negedge clk);
    chk("status_overflow_full", read_data, 32'hD);
    @(posedge clk); #1;
    store(STA, 32'h8, 2'b10);
    @(negedge clk);
    chk("status_overflow_cleared", read_data, 32'h5);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (read_data[0] !== 1'b1) break;
      n++;
    end
    chk("back_to_back_busy_cycles", 32'(n), 32'd193);
    @(posedge clk); #1;

    // Reset mid-DATA aborts frame and empties FIFO; RAM survives
    for (int i = 0; i < 3; i++) begin
      addr = TXA; write_data = (i == 0) ? 32'h3C : 32'h77 + 32'(i); mem_ctrl = 2'b10; we = 1'b1;
      @(posedge clk); #1;
    end
    we = 1'b0; addr = STA;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_line_low", {31'h0, uart_tx}, 32'h0);
    reset = 1'b1;
    #1;
    chk("reset_midframe_line_high", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("status_after_reset", read_data, 32'h2);
    repeat (50) @(posedge clk);
    #1;
    chk("idle_after_reset", {31'h0, uart_tx}, 32'h1);
    rd(32'h40, 32'h2233_11EF, "ram_retained_over_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
